prbs_par_gen: RTL and testbench

// - Parallel PRBS generator: the transmit-side counterpart of the on-chip PRBS checker.
// - Emits n_channels PRBS bits per clk from a JTAG-programmable LFSR (equation, seed).
// - Sits in the digital core ahead of the TX/loopback data mux.
// - Lets the PRBS checker run BER tests on internally generated data.
// - Its reset is driven by the prbs_gen branch of the ctrl_rstb sequencer.

---
 rtl/prbs_par_gen_if.sv | 11 +
 rtl/prbs_par_gen.sv | 162 ++++++++++++++++
 tb/tb_prbs_par_gen.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prbs_par_gen_if.sv
// Output bundle of the parallel PRBS generator: one word per clk plus its valid flag.
// The generator drives the master side; the TX/loopback mux or checker takes the slave side.
interface prbs_par_gen_if #(
  parameter int n_channels = 16
);
  logic [n_channels-1:0] data;
  logic                  data_valid;

  modport master (output data, output data_valid);
  modport slave  (input  data, input  data_valid);
endinterface

// File: rtl/prbs_par_gen.sv
// Parallel PRBS generator: n_channels LFSR steps per RUN clock, programmable tap mask and seed.
// Optional error injection is compiled in with `define PRBS_GEN_ERR_INJ_EN.
module prbs_par_gen #(
  parameter int  n_prbs     = 32,
  parameter int  n_channels = 16,
  parameter int  n_cnt      = 32,
  localparam int LaneW      = (n_channels > 1) ? $clog2(n_channels) : 1
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [n_prbs-1:0] eqn,
  input  logic [n_prbs-1:0] seed,
  input  logic              load,
  input  logic              run,
  input  logic              stop,
  prbs_par_gen_if.master    tx,
  output logic [1:0]        state_out,
`ifdef PRBS_GEN_ERR_INJ_EN
  input  logic              inj_err,
  input  logic [LaneW-1:0]  inj_lane,
  output logic [n_cnt-1:0]  err_cnt,
`endif
  output logic [n_cnt-1:0]  word_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOADED = 2'b01,
    ST_RUN    = 2'b10,
    ST_HOLD   = 2'b11
  } state_e;

  localparam logic [n_prbs-1:0] LfsrOne = {{(n_prbs-1){1'b0}}, 1'b1};
  localparam logic [n_cnt-1:0]  CntOne  = {{(n_cnt-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [n_prbs-1:0]     lfsr_q, lfsr_d;
  logic [n_channels-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [n_cnt-1:0]      cnt_q, cnt_d;

  logic [n_prbs-1:0]     step_s;
  logic [n_channels-1:0] step_w;
  logic                  step_b;
  logic                  gen;
  logic [n_channels-1:0] flip;

  // A word is produced only on edges that leave the FSM in RUN: load and stop both pre-empt it.
  assign gen = (state_q == ST_RUN) && !load && !stop;

  always_comb begin
    step_s = lfsr_q;
    step_w = '0;
    step_b = 1'b0;
    for (int i = 0; i < n_channels; i++) begin
      if (step_s == '0) step_s = LfsrOne;
      step_b    = ^(step_s & eqn);
      step_s    = {step_s[n_prbs-2:0], step_b};
      step_w[i] = step_b;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = ST_LOADED;
    end else if (stop) begin
      if (state_q == ST_RUN) state_d = ST_HOLD;
    end else if (run) begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    if (load) begin
      lfsr_d = (seed == '0) ? LfsrOne : seed;
      data_d = '0;
      cnt_d  = '0;
    end else if (gen) begin
      lfsr_d  = step_s;
      data_d  = step_w ^ flip;
      valid_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LfsrOne;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PRBS_GEN_ERR_INJ_EN
  logic             inj_prev_q;
  logic             pend_q, pend_d;
  logic [LaneW-1:0] lane_q, lane_d;
  logic [n_cnt-1:0] errc_q, errc_d;
  logic             inj_rise;
  logic [LaneW-1:0] flip_lane;

  // Only the output word is corrupted; the LFSR keeps running clean so the checker resyncs for free.
  assign inj_rise  = inj_err && !inj_prev_q;
  assign flip_lane = inj_rise ? inj_lane : lane_q;

  always_comb begin
    pend_d = pend_q;
    lane_d = lane_q;
    errc_d = errc_q;
    flip   = '0;
    if (inj_rise) begin
      pend_d = 1'b1;
      lane_d = inj_lane;
    end
    if (load) begin
      pend_d = 1'b0;
      errc_d = '0;
    end else if (gen && (pend_q || inj_rise)) begin
      flip[flip_lane] = 1'b1;
      pend_d          = 1'b0;
      if (errc_q != '1) errc_d = errc_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      inj_prev_q <= 1'b0;
      pend_q     <= 1'b0;
      lane_q     <= '0;
      errc_q     <= '0;
    end else begin
      inj_prev_q <= inj_err;
      pend_q     <= pend_d;
      lane_q     <= lane_d;
      errc_q     <= errc_d;
    end
  end

  assign err_cnt = errc_q;
`else
  assign flip = '0;
`endif

  assign tx.data       = data_q;
  assign tx.data_valid = valid_q;
  assign state_out     = state_q;
  assign word_cnt      = cnt_q;

endmodule

// File: tb/tb_prbs_par_gen.sv
// Bench for prbs_par_gen: a PRBS7 instance and a 32-bit instance share load/run/stop and are
// scored against serial LFSR models; build with PRBS_GEN_ERR_INJ_EN to cover error injection.
module tb_prbs_par_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstb;
  logic        load, run, stop;
  logic [6:0]  eqn7, seed7;
  logic [31:0] eqn32, seed32;
  logic [1:0]  st7, st32;
  logic [31:0] wc7, wc32;

  prbs_par_gen_if #(.n_channels(16)) if7 ();
  prbs_par_gen_if #(.n_channels(16)) if32 ();

`ifdef PRBS_GEN_ERR_INJ_EN
  logic        inj_err;
  logic [3:0]  inj_lane;
  logic [31:0] ec7, ec32;
`endif

  prbs_par_gen #(.n_prbs(7), .n_channels(16), .n_cnt(32)) u_dut7 (
    .clk(clk), .rstb(rstb), .eqn(eqn7), .seed(seed7),
    .load(load), .run(run), .stop(stop), .tx(if7), .state_out(st7),
`ifdef PRBS_GEN_ERR_INJ_EN
    .inj_err(inj_err), .inj_lane(inj_lane), .err_cnt(ec7),
`endif
    .word_cnt(wc7)
  );

  prbs_par_gen #(.n_prbs(32), .n_channels(16), .n_cnt(32)) u_dut32 (
    .clk(clk), .rstb(rstb), .eqn(eqn32), .seed(seed32),
    .load(load), .run(run), .stop(stop), .tx(if32), .state_out(st32),
`ifdef PRBS_GEN_ERR_INJ_EN
    .inj_err(1'b0), .inj_lane(4'd0), .err_cnt(ec32),
`endif
    .word_cnt(wc32)
  );

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp32_q[$];
  logic [15:0] obs7_q[$];
  int          err_bits = 0;
  int          total_bits = 0;
  logic [6:0]  m7;
  logic [31:0] m32;
  logic [15:0] last7;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (if7.data_valid === 1'b1) begin
      obs7_q.push_back(if7.data);
      chk("exp7_avail", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) chk("word7", 64'(if7.data), 64'(exp_q.pop_front()));
    end
  end

  // Bit-error counting in the style of the on-chip checker for the 32-bit lane group.
  always @(negedge clk) begin
    if (if32.data_valid === 1'b1) begin
      if (exp32_q.size() == 0) err_bits += 16;
      else err_bits += $countones(if32.data ^ exp32_q.pop_front());
      total_bits += 16;
    end
  end

  // ---------------- serial golden models ----------------
  task automatic next7(output logic [15:0] w);
    logic b;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      b    = ^(m7 & eqn7);
      m7   = {m7[5:0], b};
      w[i] = b;
    end
  endtask

  task automatic next32(output logic [15:0] w);
    logic b;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      b    = ^(m32 & eqn32);
      m32  = {m32[30:0], b};
      w[i] = b;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called on a negedge; optionally starts RUN, takes k words, then stops and holds 'hold' clks.
  task automatic gen_words(input int k, input int hold, input bit start, input logic [15:0] flip0);
    logic [15:0] w;
    for (int j = 0; j < k; j++) begin
      next7(w);
      if (j == 0) w = w ^ flip0;
      exp_q.push_back(w);
      last7 = w;
      next32(w);
      exp32_q.push_back(w);
    end
    if (start) begin
      run = 1'b1;
      @(negedge clk);
      chk("start_state", 64'(st7), 64'(2'b10));
      chk("start_no_word", 64'(if7.data_valid), 64'(0));
      run = 1'b0;
    end
    repeat (k) @(negedge clk);
    stop = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(if7.data_valid), 64'(0));
      chk("hold_data", 64'(if7.data), 64'(last7));
      chk("hold_state", 64'(st7), 64'(2'b11));
    end
    stop = 1'b0;
    chk("drain7", 64'(exp_q.size()), 64'(0));
    chk("drain32", 64'(exp32_q.size()), 64'(0));
  endtask

  task automatic do_load();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("load_state", 64'(st7), 64'(2'b01));
    chk("load_data", 64'(if7.data), 64'(0));
    chk("load_cnt", 64'(wc7), 64'(0));
    m7  = (seed7 == '0) ? 7'd1 : seed7;
    m32 = (seed32 == '0) ? 32'd1 : seed32;
    obs7_q.delete();
    err_bits   = 0;
    total_bits = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not complete");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] w;
    rstb = 1'b0; load = 1'b0; run = 1'b0; stop = 1'b0;
    eqn7 = 7'h60; seed7 = 7'h01; eqn32 = 32'h0010_0002; seed32 = 32'h1;
`ifdef PRBS_GEN_ERR_INJ_EN
    inj_err = 1'b0; inj_lane = 4'd0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_state", 64'(st7), 64'(0));
    chk("rst_data", 64'(if7.data), 64'(0));
    chk("rst_valid", 64'(if7.data_valid), 64'(0));
    chk("rst_cnt", 64'(wc7), 64'(0));
    chk("rst_state32", 64'(st32), 64'(0));
    rstb = 1'b1;
    @(negedge clk);
    chk("idle_stays", 64'(st7), 64'(0));

    // Never-loaded run starts from lfsr=1.
    m7 = 7'd1; m32 = 32'd1;
    gen_words(3, 2, 1'b1, 16'h0);
    chk("cnt_after3", 64'(wc7), 64'(3));

    // PRBS7: full period, repeat of word 0 at word 127.
    do_load();
    gen_words(127, 1, 1'b1, 16'h0);
    chk("cnt_127", 64'(wc7), 64'(127));
    gen_words(1, 1, 1'b1, 16'h0);
    chk("obs_count", 64'(obs7_q.size()), 64'(128));
    if (obs7_q.size() == 128) chk("period_127", 64'(obs7_q[127]), 64'(obs7_q[0]));

    // Pause after word 5 for 10 clks, then continue to 600 words on the 32-bit instance.
    do_load();
    gen_words(5, 10, 1'b1, 16'h0);
    gen_words(595, 1, 1'b1, 16'h0);
    chk("err_bits32", 64'(err_bits), 64'(0));
    chk("total_bits32", 64'(total_bits), 64'(9600));
    chk("cnt32_600", 64'(wc32), 64'(600));

    // load + run together with a zero seed: load wins, lfsr=1, run only on the next edge.
    seed7 = 7'h00; seed32 = 32'h0;
    run = 1'b1;
    do_load();
    chk("prio_valid", 64'(if7.data_valid), 64'(0));
    @(negedge clk);
    chk("prio_run_next", 64'(st7), 64'(2'b10));
    chk("prio_no_word", 64'(if7.data_valid), 64'(0));
    run = 1'b0;
    gen_words(4, 1, 1'b0, 16'h0);
    chk("prio_cnt", 64'(wc7), 64'(4));

`ifdef PRBS_GEN_ERR_INJ_EN
    seed7 = 7'h01; seed32 = 32'h1;
    do_load();
    gen_words(21, 1, 1'b1, 16'h0);
    inj_lane = 4'd3;
    inj_err  = 1'b1;
    @(negedge clk);
    inj_err = 1'b0;
    chk("inj_pending_cnt", 64'(ec7), 64'(0));
    gen_words(5, 1, 1'b1, 16'h0008);
    chk("inj_err_cnt", 64'(ec7), 64'(1));
    do_load();
    chk("inj_cnt_cleared", 64'(ec7), 64'(0));
`endif

    // Asynchronous reset in the middle of RUN.
    seed7 = 7'h01; seed32 = 32'h1;
    do_load();
    for (int j = 0; j < 10; j++) begin
      next7(w);  exp_q.push_back(w);
      next32(w); exp32_q.push_back(w);
    end
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_valid", 64'(if7.data_valid), 64'(1));
    #2 rstb = 1'b0;
    #1;
    chk("async_state", 64'(st7), 64'(0));
    chk("async_data", 64'(if7.data), 64'(0));
    chk("async_valid", 64'(if7.data_valid), 64'(0));
    chk("async_cnt", 64'(wc7), 64'(0));
    chk("async_state32", 64'(st32), 64'(0));
    exp_q.delete();
    exp32_q.delete();
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 64'(st7), 64'(0));
    chk("post_reset_valid", 64'(if7.data_valid), 64'(0));

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
